// File: rtl/ft60x_pkg.sv
// Shared types for the FT60X transmit writer: FSM states, FIFO entry, bus constants.
package ft60x_pkg;
  localparam int DATA_W      = 8;
  localparam int TURN_CYCLES = 1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_TURN    = 2'd1,
    ST_WRITE   = 2'd2,
    ST_RELEASE = 2'd3
  } state_t;

  typedef struct packed {
    logic              last;
    logic [DATA_W-1:0] dat;
  } entry_t;
endpackage

// File: rtl/ft60x_tx_fifo.sv
// First-word fall-through byte FIFO with per-entry message-end flag.
// Latency: a pushed entry is visible at head on the next cycle.
// Backpressure: full blocks push via the writer's ready; pop only when non-empty.
module ft60x_tx_fifo
  import ft60x_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  entry_t            wr_dat,
  input  logic              pop,
  output entry_t            head,
  output logic [DATA_W-1:0] next_dat,
  output logic [AW:0]       count,
  output logic              full,
  output logic              empty
);
  entry_t        mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_dat;
  end

  // next_dat is only consumed when at least two entries are held
  assign head     = mem[rd_ptr];
  assign next_dat = mem[rd_ptr + AW'(1)].dat;
  assign full     = (count == (AW+1)'(DEPTH));
  assign empty    = (count == '0);
endmodule

// File: rtl/ft60x_tx_writer.sv
// FT60X transmit writer: buffers stream bytes and bursts them out on the shared bus.
// Latency: first ftdi_wr_n low 2 cycles after the start condition holds in IDLE.
// Backpressure: s_ready = FIFO not full; ftdi_txe_n high holds data and wr_n. Option: FT60X_TX_SIWU_EN.
module ft60x_tx_writer
  import ft60x_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = 4,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  input  logic              s_last,
  output logic              s_ready,
  input  logic              bus_busy,
  input  logic              ftdi_txe_n,
  output logic              ftdi_wr_n,
  output logic [DATA_W-1:0] ftdi_data_out,
  output logic              ftdi_data_oe,
  output logic              tx_active,
  output logic [CNT_W-1:0]  bytes_sent
`ifdef FT60X_TX_SIWU_EN
  ,
  output logic              ftdi_siwu_n
`endif
);
  state_t            state, state_nxt;
  entry_t            head;
  logic [DATA_W-1:0] next_dat;
  logic [AW:0]       count;
  logic              full, empty;
  logic              push, accept, start, burst_end, turn_done;
  logic [1:0]        turn_cnt;
  logic              wr_n_nxt, own_nxt;
  logic [DATA_W-1:0] data_nxt;

  assign s_ready   = !full;
  assign push      = s_valid && s_ready;
  assign accept    = !ftdi_wr_n && !ftdi_txe_n;
  assign start     = !empty && !bus_busy && !ftdi_txe_n;
  // A message boundary or draining the FIFO ends the burst
  assign burst_end = accept && ((count == (AW+1)'(1)) || head.last);
  assign turn_done = (turn_cnt == 2'(TURN_CYCLES - 1));

  ft60x_tx_fifo #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .wr_dat   ('{last: s_last, dat: s_data}),
    .pop      (accept),
    .head     (head),
    .next_dat (next_dat),
    .count    (count),
    .full     (full),
    .empty    (empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_IDLE;
      turn_cnt      <= '0;
      ftdi_wr_n     <= 1'b1;
      ftdi_data_oe  <= 1'b0;
      tx_active     <= 1'b0;
      ftdi_data_out <= '0;
      bytes_sent    <= '0;
    end else begin
      state         <= state_nxt;
      turn_cnt      <= (state == ST_TURN) ? turn_cnt + 2'd1 : 2'd0;
      ftdi_wr_n     <= wr_n_nxt;
      ftdi_data_oe  <= own_nxt;
      tx_active     <= own_nxt;
      ftdi_data_out <= data_nxt;
      if (accept) bytes_sent <= bytes_sent + CNT_W'(1);
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:    if (start)     state_nxt = ST_TURN;
      ST_TURN:    if (turn_done) state_nxt = ST_WRITE;
      ST_WRITE:   if (burst_end) state_nxt = ST_RELEASE;
      ST_RELEASE: state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    wr_n_nxt = (state_nxt != ST_WRITE);
    own_nxt  = (state_nxt != ST_IDLE);
    data_nxt = ftdi_data_out;
    if (state == ST_TURN && state_nxt == ST_WRITE) begin
      data_nxt = head.dat;
    end else if (accept && !burst_end) begin
      data_nxt = next_dat;
    end
  end

`ifdef FT60X_TX_SIWU_EN
  // Short-packet flush pulse during RELEASE when the burst ended on a message boundary
  always_ff @(posedge clk) begin
    if (rst) ftdi_siwu_n <= 1'b1;
    else     ftdi_siwu_n <= !(burst_end && head.last);
  end
`endif
endmodule

// File: tb/tb_ft60x_tx_writer.sv
// Bench for ft60x_tx_writer: queue-based host model checked every cycle plus directed literal checks.
module tb_ft60x_tx_writer;
  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] s_data = '0;
  logic       s_valid = 1'b0;
  logic       s_last = 1'b0;
  logic       s_ready;
  logic       bus_busy = 1'b0;
  logic       ftdi_txe_n = 1'b1;
  logic       ftdi_wr_n;
  logic [7:0] ftdi_data_out;
  logic       ftdi_data_oe;
  logic       tx_active;
  logic [15:0] bytes_sent;
`ifdef FT60X_TX_SIWU_EN
  logic       ftdi_siwu_n;
`endif

  always #5 clk = ~clk;

  ft60x_tx_writer #(.DEPTH(16), .AW(4), .CNT_W(16)) dut (
    .clk           (clk),
    .rst           (rst),
    .s_data        (s_data),
    .s_valid       (s_valid),
    .s_last        (s_last),
    .s_ready       (s_ready),
    .bus_busy      (bus_busy),
    .ftdi_txe_n    (ftdi_txe_n),
    .ftdi_wr_n     (ftdi_wr_n),
    .ftdi_data_out (ftdi_data_out),
    .ftdi_data_oe  (ftdi_data_oe),
    .tx_active     (tx_active),
    .bytes_sent    (bytes_sent)
`ifdef FT60X_TX_SIWU_EN
    ,
    .ftdi_siwu_n   (ftdi_siwu_n)
`endif
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    failures++;
    $display("FAIL %s timed out at %0t", name, $time);
  endtask

  // Host-side model: bytes the host must receive, in order, with their message-end flag
  logic [8:0] exp_q[$];
  logic [7:0] host_log[$];
  int         sent = 0;
  bit         mon_en = 0;
  bit         prev_hold = 0;
  bit         prev_idle_busy = 0;
  bit         exp_siwu = 0;
  logic [7:0] prev_dat = '0;

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      host_log.delete();
      sent = 0;
      prev_hold = 0;
      prev_idle_busy = 0;
      exp_siwu = 0;
    end else if (mon_en) begin
      chk("bytes_sent", 32'(bytes_sent), 32'(sent) & 32'hFFFF);
      chk("s_ready", 32'(s_ready), 32'(exp_q.size() < DEPTH));
      if (!ftdi_wr_n) chk("own_while_writing", {30'd0, ftdi_data_oe, tx_active}, 32'd3);
      if (prev_hold) begin
        chk("hold_wr_n", 32'(ftdi_wr_n), 32'd0);
        chk("hold_data", 32'(ftdi_data_out), 32'(prev_dat));
      end
      if (prev_idle_busy) chk("busy_blocks_start", 32'(tx_active), 32'd0);
`ifdef FT60X_TX_SIWU_EN
      chk("siwu_n", 32'(ftdi_siwu_n), 32'(!exp_siwu));
`endif
      exp_siwu = 0;
      if (!ftdi_wr_n && !ftdi_txe_n) begin
        if (exp_q.size() == 0) begin
          timeout_fail("spurious_accept");
        end else begin
          chk("host_byte", 32'(ftdi_data_out), 32'(exp_q[0][7:0]));
          exp_siwu = exp_q[0][8];
          host_log.push_back(ftdi_data_out);
          void'(exp_q.pop_front());
          sent++;
        end
      end
      if (s_valid && s_ready) exp_q.push_back({s_last, s_data});
      prev_hold      = !ftdi_wr_n && ftdi_txe_n;
      prev_dat       = ftdi_data_out;
      prev_idle_busy = !tx_active && bus_busy;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] d, input logic l);
    bit done = 0;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = l;
    for (int i = 0; i < 300 && !done; i++) begin
      @(negedge clk);
      done = s_ready;
      step();
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    if (!done) timeout_fail("push");
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    @(negedge clk);
    chk("rst_wr_n", 32'(ftdi_wr_n), 32'd1);
    chk("rst_oe", 32'(ftdi_data_oe), 32'd0);
    chk("rst_data", 32'(ftdi_data_out), 32'd0);
    chk("rst_tx_active", 32'(tx_active), 32'd0);
    chk("rst_bytes_sent", 32'(bytes_sent), 32'd0);
    chk("rst_s_ready", 32'(s_ready), 32'd1);
`ifdef FT60X_TX_SIWU_EN
    chk("rst_siwu_n", 32'(ftdi_siwu_n), 32'd1);
`endif
    step();
    rst = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    bit done = 0;
    for (int i = 0; i < 400 && !done; i++) begin
      step();
      done = !tx_active && ftdi_wr_n && (exp_q.size() == 0);
    end
    if (!done) timeout_fail(name);
  endtask

  task automatic wait_sent(input int n, input string name);
    bit done = 0;
    for (int i = 0; i < 400 && !done; i++) begin
      step();
      done = (sent >= n);
    end
    if (!done) timeout_fail(name);
  endtask

  // Single burst cycle table: {oe, wr_n, tx_active}, data when writing, bytes_sent
  logic [2:0] t1_ctl [7] = '{3'b010, 3'b111, 3'b101, 3'b101, 3'b101, 3'b111, 3'b010};
  logic [7:0] t1_dat [7] = '{8'h00, 8'h00, 8'hA5, 8'hA6, 8'hA7, 8'h00, 8'h00};
  logic [7:0] t1_bs  [7] = '{8'd0, 8'd0, 8'd0, 8'd1, 8'd2, 8'd3, 8'd3};

  initial begin
    int lows;
    do_reset();
    mon_en = 1;

    // Single burst A5,A6,A7 with last on A7
    ftdi_txe_n = 1'b0;
    s_valid = 1'b1; s_data = 8'hA5; s_last = 1'b0;
    for (int k = 0; k < 7; k++) begin
      step();
      if (k == 0) s_data = 8'hA6;
      if (k == 1) begin s_data = 8'hA7; s_last = 1'b1; end
      if (k == 2) begin s_valid = 1'b0; s_last = 1'b0; end
      @(negedge clk);
      chk("t1_ctl", {29'd0, ftdi_data_oe, ftdi_wr_n, tx_active}, 32'(t1_ctl[k]));
      if (!t1_ctl[k][1]) chk("t1_data", 32'(ftdi_data_out), 32'(t1_dat[k]));
      chk("t1_bytes_sent", 32'(bytes_sent), 32'(t1_bs[k]));
    end
    step();
    chk("t1_host_count", 32'(host_log.size()), 32'd3);
    if (host_log.size() == 3) chk("t1_host_seq", {8'd0, host_log[0], host_log[1], host_log[2]}, 32'h00A5A6A7);

    // TX stall after byte 3
    do_reset();
    ftdi_txe_n = 1'b1;
    for (int i = 0; i < 8; i++) push(8'(8'h10 + i), i == 7);
    @(negedge clk);
    chk("t2_no_start_txe", 32'(tx_active), 32'd0);
    step();
    ftdi_txe_n = 1'b0;
    wait_sent(3, "t2_first3");
    ftdi_txe_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t2_stall_wr_n", 32'(ftdi_wr_n), 32'd0);
      chk("t2_stall_data", 32'(ftdi_data_out), 32'h13);
      step();
    end
    ftdi_txe_n = 1'b0;
    wait_idle("t2_drain");
    chk("t2_bytes_sent", 32'(bytes_sent), 32'd8);
    chk("t2_host_count", 32'(host_log.size()), 32'd8);
    foreach (host_log[i]) chk("t2_host_seq", 32'(host_log[i]), 32'(8'h10 + i));

    // Arbitration: receive path owns the bus
    do_reset();
    bus_busy = 1'b1;
    push(8'h5A, 1'b0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t3_busy_oe", 32'(ftdi_data_oe), 32'd0);
      chk("t3_busy_active", 32'(tx_active), 32'd0);
      step();
    end
    bus_busy = 1'b0;
    @(negedge clk);
    chk("t3_idle_cycle", 32'(tx_active), 32'd0);
    step();
    @(negedge clk);
    chk("t3_turn", {29'd0, ftdi_data_oe, ftdi_wr_n, tx_active}, 32'b111);
    wait_idle("t3_drain");
    chk("t3_bytes_sent", 32'(bytes_sent), 32'd1);

    // Full FIFO: 20 bytes with txe_n high, then release
    do_reset();
    ftdi_txe_n = 1'b1;
    for (int i = 0; i < 16; i++) push(8'(i), 1'b0);
    @(negedge clk);
    chk("t4_full_ready", 32'(s_ready), 32'd0);
    step();
    ftdi_txe_n = 1'b0;
    for (int i = 16; i < 20; i++) push(8'(i), i == 19);
    wait_idle("t4_drain");
    chk("t4_bytes_sent", 32'(bytes_sent), 32'd20);
    chk("t4_host_count", 32'(host_log.size()), 32'd20);
    foreach (host_log[i]) chk("t4_host_seq", 32'(host_log[i]), 32'(i));

    // Reset in the middle of a burst
    do_reset();
    ftdi_txe_n = 1'b1;
    for (int i = 0; i < 6; i++) push(8'(8'h30 + i), 1'b0);
    step();
    ftdi_txe_n = 1'b0;
    wait_sent(2, "t5_progress");
    chk("t5_mid_wr_n", 32'(ftdi_wr_n), 32'd0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("t5_wr_n", 32'(ftdi_wr_n), 32'd1);
    chk("t5_oe", 32'(ftdi_data_oe), 32'd0);
    chk("t5_bytes_sent", 32'(bytes_sent), 32'd0);
    chk("t5_s_ready", 32'(s_ready), 32'd1);
    for (int i = 0; i < 3; i++) begin
      step();
      @(negedge clk);
      chk("t5_discarded", 32'(tx_active), 32'd0);
    end
    step();

    // Two-byte message: flush pulse when SIWU is built in
    do_reset();
    ftdi_txe_n = 1'b0;
    push(8'h61, 1'b0);
    push(8'h62, 1'b1);
    lows = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
`ifdef FT60X_TX_SIWU_EN
      if (!ftdi_siwu_n) begin
        lows++;
        chk("t6_siwu_in_release", {30'd0, ftdi_wr_n, ftdi_data_oe}, 32'b11);
      end
`endif
      step();
    end
`ifdef FT60X_TX_SIWU_EN
    chk("t6_siwu_pulses", 32'(lows), 32'd1);
`endif
    chk("t6_bytes_sent", 32'(bytes_sent), 32'd2);
    chk("t6_model_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end
endmodule
